tpu_aclr_release_seq: RTL and testbench
=======================================

// Module: tpu_aclr_release_seq
// PURPOSE
//  Produces the per-stage aclr nets that drive the TPU's async-clear registers.
//  - Assertion is asynchronous and immediate.
//  - Deassertion is synchronised to clk, stretched, then released stage by stage
//    (stage 0 first), so that pipeline stages leave reset in order.
//  - Also accepts a synchronous soft-reset request that re-runs the same sequence.
// PARAMETERS
//  NUM_STAGES   4   number of aclr_out nets; >=1
//  SYNC_DEPTH   2   flops in the release synchroniser; >=2
//  HOLD_CYCLES  16  clk cycles all stages stay in reset after sync; >=1
//  GAP_CYCLES   4   clk cycles between successive stage releases; >=1
//  CNT_WIDTH    8   width of soft-reset event counter (optional feature only)
// PORTS
//  clk            in   1           clock
//  aclr           in   1           reset, asynchronous, active-high
//  soft_rst_req   in   1           sync pulse: request full reset re-sequence
//  aclr_out       out  NUM_STAGES  per-stage async clear, active-high
//  rst_busy       out  1           1 while any aclr_out bit is high
//  rst_done       out  1           1 when all stages released (== ~rst_busy)
//  rst_event_cnt  out  CNT_WIDTH   soft-reset count (present only with ACLR_SEQ_CNT_EN)
// BEHAVIOUR
//  Reset values while aclr=1 (asynchronous, no clock needed):
//   - aclr_out='1, rst_busy=1, rst_done=0, rst_event_cnt=0
//   - sync chain=0, FSM=S_SYNC
//  FSM states: S_SYNC -> S_HOLD -> S_GAP -> S_DONE.
//   - S_SYNC: chain shifts in 1; when its last flop is 1, go to S_HOLD and
//     load hold_cnt=HOLD_CYCLES-1.
//   - S_HOLD: decrement hold_cnt; at 0, clear aclr_out[0]. If NUM_STAGES==1, go
//     to S_DONE; else go to S_GAP with stg_idx=1 and gap_cnt=GAP_CYCLES-1.
//   - S_GAP: decrement gap_cnt; at 0, clear aclr_out[stg_idx] and increment
//     stg_idx. After the last stage, go to S_DONE; else reload gap_cnt.
//   - S_DONE: rst_busy=0, rst_done=1.
//  Timing (edges counted from the first clk rising edge after aclr falls):
//   - aclr_out[k] falls at edge SYNC_DEPTH+HOLD_CYCLES+k*GAP_CYCLES.
//     Defaults: edges 18, 22, 26, 30.
//   - rst_done rises on the same edge as aclr_out[NUM_STAGES-1] falls.
//   - aclr_out bits fall only in index order; a released bit never re-rises
//     except via aclr or soft reset.
//  soft_rst_req:
//   - Sampled only in S_DONE. On that edge: aclr_out='1, rst_busy=1, rst_done=0,
//     FSM -> S_HOLD with hold_cnt reloaded. The synchroniser is bypassed (the
//     request is already synchronous).
//   - Ignored (not queued) in every other state.
//  aclr mid-sequence (any state): immediately forces the reset values above;
//   the sequence restarts from S_SYNC when aclr falls.
//  aclr pulse shorter than one clk period still forces the full sequence.
//  aclr_out bits are flop outputs only (never combinational), so they are
//   glitch-free.
// CONFIGURATION
//  ACLR_SEQ_CNT_EN defined:
//   - rst_event_cnt exists; +1 on each accepted soft_rst_req.
//   - Saturates at 2**CNT_WIDTH-1; cleared only by aclr.
//  ACLR_SEQ_CNT_EN undefined:
//   - port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package tpu_rst_pkg:
//   - typedef enum logic [1:0] {S_SYNC,S_HOLD,S_GAP,S_DONE} rst_seq_state_t
//   - default localparams for NUM_STAGES, SYNC_DEPTH, HOLD_CYCLES, GAP_CYCLES
//  Sub-module aclr_sync: SYNC_DEPTH-flop chain, async-cleared by aclr, D of the
//   first flop tied to 1; output rel_sync. Instantiated once.
//  Counter widths: $clog2(HOLD_CYCLES), $clog2(GAP_CYCLES), $clog2(NUM_STAGES),
//   each with a minimum of 1 bit.
// TESTING
//  1 Defaults; aclr 1 for 3 cycles, then 0 -> aclr_out 4'hF until edge 18; then
//    4'hE, 4'hC@22, 4'h8@26, 4'h0@30; rst_done=1@30.
//  2 Raise aclr mid-clock at edge 24 (aclr_out=4'hC) -> aclr_out=4'hF and
//    rst_done=0 before the next edge; after aclr falls, full timing from scenario 1.
//  3 In S_DONE, 1-cycle soft_rst_req -> next edge aclr_out=4'hF; stage 0
//    released 16 edges later, then 4-cycle gaps; cnt=1 (with ACLR_SEQ_CNT_EN).
//  4 soft_rst_req asserted during S_HOLD and S_GAP -> no effect on timing;
//    cnt unchanged.
//  5 NUM_STAGES=1, HOLD_CYCLES=1, SYNC_DEPTH=2 -> aclr_out falls at edge 3;
//    rst_done rises at edge 3.
//  6 ACLR_SEQ_CNT_EN, CNT_WIDTH=2; 5 soft resets, each in S_DONE -> cnt reads
//    1, 2, 3, 3, 3; aclr -> cnt=0.

Source files
------------

// File: rtl/tpu_rst_pkg.sv
// tpu_rst_pkg: shared state encoding, default parameters and counter-width helper for the aclr release sequencer
package tpu_rst_pkg;
  typedef enum logic [1:0] {S_SYNC, S_HOLD, S_GAP, S_DONE} rst_seq_state_t;
  localparam int DEF_NUM_STAGES = 4;
  localparam int DEF_SYNC_DEPTH = 2;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_GAP_CYCLES = 4;
  localparam int DEF_CNT_WIDTH = 8;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/aclr_sync.sv
// aclr_sync: release synchroniser for aclr; the sequencer's state register is its final stage, so the first count starts SYNC_DEPTH edges after release
module aclr_sync #(
  parameter int SYNC_DEPTH = 2
) (
  input  logic clk,
  input  logic aclr,
  output logic rel_sync
);
  localparam int N = SYNC_DEPTH - 1;
  logic [N-1:0] r_chain;
  // shift ones in once aclr has been released
  always_ff @(posedge clk or posedge aclr)
    if (aclr) r_chain <= '0;
    else r_chain <= (r_chain << 1) | N'(1);
  assign rel_sync = r_chain[N-1];
endmodule

// File: rtl/tpu_aclr_release_seq.sv
// tpu_aclr_release_seq: staged per-stage aclr release sequencer; ACLR_SEQ_CNT_EN adds a saturating soft-reset event counter
module tpu_aclr_release_seq
  import tpu_rst_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int SYNC_DEPTH = DEF_SYNC_DEPTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
`ifdef ACLR_SEQ_CNT_EN
  , parameter int CNT_WIDTH = DEF_CNT_WIDTH
`endif
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] aclr_out,
  output logic                  rst_busy,
  output logic                  rst_done
`ifdef ACLR_SEQ_CNT_EN
  , output logic [CNT_WIDTH-1:0] rst_event_cnt
`endif
);
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam int GW = cnt_w(GAP_CYCLES);
  localparam int SW = cnt_w(NUM_STAGES);
  rst_seq_state_t r_state, w_state_nxt;
  logic [HW-1:0] r_hold_cnt, w_hold_nxt;
  logic [GW-1:0] r_gap_cnt, w_gap_nxt;
  logic [SW-1:0] r_stg_idx, w_idx_nxt;
  logic [NUM_STAGES-1:0] r_aclr_out, w_aclr_nxt;
  logic w_rel_sync, w_soft_acc;
  aclr_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync (
    .clk      (clk),
    .aclr     (aclr),
    .rel_sync (w_rel_sync)
  );
  assign w_soft_acc = (r_state == S_DONE) && soft_rst_req;
  // next state, hold/gap countdowns and in-order stage release
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt = r_hold_cnt;
    w_gap_nxt = r_gap_cnt;
    w_idx_nxt = r_stg_idx;
    w_aclr_nxt = r_aclr_out;
    case (r_state)
      S_SYNC: if (w_rel_sync) begin
        w_state_nxt = S_HOLD;
        w_hold_nxt = HW'(HOLD_CYCLES - 1);
      end
      S_HOLD: if (r_hold_cnt != '0) w_hold_nxt = r_hold_cnt - HW'(1);
      else begin
        w_aclr_nxt[0] = 1'b0;
        w_state_nxt = (NUM_STAGES == 1) ? S_DONE : S_GAP;
        w_idx_nxt = SW'(1);
        w_gap_nxt = GW'(GAP_CYCLES - 1);
      end
      S_GAP: if (r_gap_cnt != '0) w_gap_nxt = r_gap_cnt - GW'(1);
      else begin
        w_aclr_nxt[r_stg_idx] = 1'b0;
        w_state_nxt = (r_stg_idx == SW'(NUM_STAGES - 1)) ? S_DONE : S_GAP;
        w_idx_nxt = r_stg_idx + SW'(1);
        w_gap_nxt = GW'(GAP_CYCLES - 1);
      end
      default: if (w_soft_acc) begin
        w_aclr_nxt = '1;
        w_state_nxt = S_HOLD;
        w_hold_nxt = HW'(HOLD_CYCLES - 1);
      end
    endcase
  end
  // sequencer registers; aclr forces every stage back into reset immediately
  always_ff @(posedge clk or posedge aclr)
    if (aclr) begin
      r_state <= S_SYNC;
      r_hold_cnt <= '0;
      r_gap_cnt <= '0;
      r_stg_idx <= '0;
      r_aclr_out <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_stg_idx <= w_idx_nxt;
      r_aclr_out <= w_aclr_nxt;
    end
  assign aclr_out = r_aclr_out;
  assign rst_busy = |r_aclr_out;
  assign rst_done = ~rst_busy;
`ifdef ACLR_SEQ_CNT_EN
  logic [CNT_WIDTH-1:0] r_event_cnt;
  // count accepted soft resets, saturating; only aclr clears it
  always_ff @(posedge clk or posedge aclr)
    if (aclr) r_event_cnt <= '0;
    else if (w_soft_acc && r_event_cnt != '1) r_event_cnt <= r_event_cnt + CNT_WIDTH'(1);
  assign rst_event_cnt = r_event_cnt;
`endif
endmodule

// File: tb/tb_tpu_aclr_release_seq.sv
// tb_tpu_aclr_release_seq: scenario and randomized bench for tpu_aclr_release_seq against a release-time model
module tb_tpu_aclr_release_seq;
  localparam int NS = 4, SD = 2, HC = 16, GC = 4;
  logic clk = 1'b0, aclr = 1'b0, req = 1'b0, req1 = 1'b0;
  logic [NS-1:0] aclr_out;
  logic rst_busy, rst_done, out1, busy1, done1;
  int errors = 0, checks = 0;
  int m_t = 0, m_base = SD + HC, m5_t = 0, m_cnt = 0;
`ifdef ACLR_SEQ_CNT_EN
  logic [7:0] cnt;
  logic [1:0] cnt_c;
  logic [NS-1:0] out_c;
  logic reqc = 1'b0, busy_c, done_c;
`endif

  always #5 clk = ~clk;

  tpu_aclr_release_seq dut (
    .clk(clk), .aclr(aclr), .soft_rst_req(req), .aclr_out(aclr_out),
    .rst_busy(rst_busy), .rst_done(rst_done)
`ifdef ACLR_SEQ_CNT_EN
    , .rst_event_cnt(cnt)
`endif
  );

  tpu_aclr_release_seq #(.NUM_STAGES(1), .HOLD_CYCLES(1), .SYNC_DEPTH(2)) dut5 (
    .clk(clk), .aclr(aclr), .soft_rst_req(req1), .aclr_out(out1),
    .rst_busy(busy1), .rst_done(done1)
`ifdef ACLR_SEQ_CNT_EN
    , .rst_event_cnt()
`endif
  );

`ifdef ACLR_SEQ_CNT_EN
  tpu_aclr_release_seq #(.CNT_WIDTH(2)) dut_c (
    .clk(clk), .aclr(aclr), .soft_rst_req(reqc), .aclr_out(out_c),
    .rst_busy(busy_c), .rst_done(done_c), .rst_event_cnt(cnt_c)
  );
`endif

  // stage k is in reset until t edges since sequence start reach base + k*GC
  function automatic logic [NS-1:0] exp_out(input int t, input int base);
    for (int k = 0; k < NS; k++) exp_out[k] = t < base + k * GC;
  endfunction

  task automatic aclr_on;
    aclr = 1'b1;
    m_t = 0;
    m_base = SD + HC;
    m5_t = 0;
    m_cnt = 0;
  endtask

  task automatic aclr_off;
    aclr = 1'b0;
  endtask

  task automatic tick(input logic r);
    req = r;
    @(posedge clk);
    if (!aclr) begin
      m5_t++;
      if (r && exp_out(m_t, m_base) == '0) begin
        m_t = 0;
        m_base = HC;
        if (m_cnt < 255) m_cnt++;
      end else m_t++;
    end
    #1;
    req = 1'b0;
  endtask

  task automatic test_reset;
    #2 aclr_on();
    #1;
    checks++;
    if (aclr_out !== 4'hF || rst_busy !== 1'b1 || rst_done !== 1'b0)
      begin errors++; $display("FAIL reset_async: out=%h busy=%b done=%b want F 1 0", aclr_out, rst_busy, rst_done); end
    repeat (3) begin
      tick(1'b1);
      checks++;
      if (aclr_out !== 4'hF || rst_done !== 1'b0 || out1 !== 1'b1)
        begin errors++; $display("FAIL reset_hold: out=%h done=%b out1=%b want F 0 1", aclr_out, rst_done, out1); end
    end
`ifdef ACLR_SEQ_CNT_EN
    checks++;
    if (cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
`endif
    aclr_off();
  endtask

  task automatic test_release;
    logic [NS-1:0] exp;
    for (int e = 1; e <= 32; e++) begin
      tick(1'b0);
      exp = e < 18 ? 4'hF : e < 22 ? 4'hE : e < 26 ? 4'hC : e < 30 ? 4'h8 : 4'h0;
      checks++;
      if (aclr_out !== exp || rst_done !== (e >= 30) || rst_busy !== (e < 30))
        begin errors++; $display("FAIL release e=%0d: out=%h done=%b want %h %b", e, aclr_out, rst_done, exp, e >= 30); end
    end
  endtask

  task automatic test_aclr_mid;
    logic [NS-1:0] exp;
    aclr_on();
    #2 aclr_off();
    for (int e = 1; e <= 24; e++) begin
      tick(1'b0);
      exp = e < 18 ? 4'hF : e < 22 ? 4'hE : 4'hC;
      checks++;
      if (aclr_out !== exp) begin errors++; $display("FAIL pre_mid e=%0d: out=%h want %h", e, aclr_out, exp); end
    end
    #3 aclr_on();
    #1;
    checks++;
    if (aclr_out !== 4'hF || rst_done !== 1'b0 || rst_busy !== 1'b1)
      begin errors++; $display("FAIL mid_aclr: out=%h done=%b busy=%b want F 0 1", aclr_out, rst_done, rst_busy); end
    @(posedge clk);
    #1 aclr_off();
    for (int e = 1; e <= 32; e++) begin
      tick(1'b0);
      exp = e < 18 ? 4'hF : e < 22 ? 4'hE : e < 26 ? 4'hC : e < 30 ? 4'h8 : 4'h0;
      checks++;
      if (aclr_out !== exp || rst_done !== (e >= 30))
        begin errors++; $display("FAIL post_mid e=%0d: out=%h done=%b want %h", e, aclr_out, rst_done, exp); end
    end
  endtask

  task automatic test_soft_reset;
    logic [NS-1:0] exp;
    tick(1'b1);
    checks++;
    if (aclr_out !== 4'hF || rst_done !== 1'b0 || rst_busy !== 1'b1)
      begin errors++; $display("FAIL soft_assert: out=%h done=%b busy=%b want F 0 1", aclr_out, rst_done, rst_busy); end
`ifdef ACLR_SEQ_CNT_EN
    checks++;
    if (cnt !== 8'd1) begin errors++; $display("FAIL soft_cnt: got %0d want 1", cnt); end
`endif
    for (int e = 1; e <= 30; e++) begin
      tick(1'b0);
      exp = e < 16 ? 4'hF : e < 20 ? 4'hE : e < 24 ? 4'hC : e < 28 ? 4'h8 : 4'h0;
      checks++;
      if (aclr_out !== exp || rst_done !== (e >= 28))
        begin errors++; $display("FAIL soft_seq e=%0d: out=%h done=%b want %h", e, aclr_out, rst_done, exp); end
    end
  endtask

  task automatic test_soft_ignored;
    logic [NS-1:0] exp;
    tick(1'b1);
    for (int e = 1; e <= 30; e++) begin
      tick(e == 5 || e == 16 || e == 17 || e == 21 || e == 24 || e == 28);
      exp = e < 16 ? 4'hF : e < 20 ? 4'hE : e < 24 ? 4'hC : e < 28 ? 4'h8 : 4'h0;
      checks++;
      if (aclr_out !== exp || rst_done !== (e >= 28))
        begin errors++; $display("FAIL soft_ignored e=%0d: out=%h done=%b want %h", e, aclr_out, rst_done, exp); end
    end
`ifdef ACLR_SEQ_CNT_EN
    checks++;
    if (cnt !== 8'd2) begin errors++; $display("FAIL ignored_cnt: got %0d want 2", cnt); end
`endif
  endtask

  task automatic test_single_stage;
    aclr_on();
    #2 aclr_off();
    for (int e = 1; e <= 5; e++) begin
      tick(1'b0);
      checks++;
      if (out1 !== (e < 3) || done1 !== (e >= 3) || busy1 !== (e < 3))
        begin errors++; $display("FAIL single e=%0d: out=%b done=%b busy=%b want %b", e, out1, done1, busy1, e < 3); end
    end
  endtask

`ifdef ACLR_SEQ_CNT_EN
  task automatic test_cnt_sat;
    logic [1:0] exp;
    aclr_on();
    #2 aclr_off();
    repeat (31) tick(1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (done_c !== 1'b1 || busy_c !== 1'b0 || out_c !== 4'h0)
        begin errors++; $display("FAIL sat_ready i=%0d: done=%b out=%h want 1 0", i, done_c, out_c); end
      reqc = 1'b1;
      tick(1'b0);
      reqc = 1'b0;
      exp = (i < 3) ? 2'(i + 1) : 2'd3;
      checks++;
      if (cnt_c !== exp) begin errors++; $display("FAIL sat_cnt i=%0d: got %0d want %0d", i, cnt_c, exp); end
      repeat (30) tick(1'b0);
    end
    aclr_on();
    #1;
    checks++;
    if (cnt_c !== 2'd0) begin errors++; $display("FAIL sat_clear: got %0d want 0", cnt_c); end
    #1 aclr_off();
  endtask
`endif

  task automatic test_random;
    logic [NS-1:0] exp;
    int r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 39);
      if (r == 0) begin
        aclr_on();
        #2;
        checks++;
        if (aclr_out !== 4'hF || rst_done !== 1'b0 || out1 !== 1'b1)
          begin errors++; $display("FAIL rand_pulse i=%0d: out=%h done=%b out1=%b", i, aclr_out, rst_done, out1); end
        aclr_off();
      end else if (r == 1) begin
        aclr_on();
        repeat ($urandom_range(1, 3)) tick(1'($urandom_range(0, 1)));
        aclr_off();
      end else begin
        tick($urandom_range(0, 3) == 0);
        exp = exp_out(m_t, m_base);
        checks++;
        if (aclr_out !== exp || rst_done !== (exp == '0) || rst_busy !== (exp != '0))
          begin errors++; $display("FAIL rand i=%0d: out=%h done=%b busy=%b want %h", i, aclr_out, rst_done, rst_busy, exp); end
        checks++;
        if (out1 !== (m5_t < SD + 1))
          begin errors++; $display("FAIL rand_single i=%0d: out1=%b want %b", i, out1, m5_t < SD + 1); end
`ifdef ACLR_SEQ_CNT_EN
        checks++;
        if (cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rand_cnt i=%0d: got %0d want %0d", i, cnt, m_cnt); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_aclr_mid();
    test_soft_reset();
    test_soft_ignored();
    test_single_stage();
`ifdef ACLR_SEQ_CNT_EN
    test_cnt_sat();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
